// File: rtl/branch_pkg.sv
// branch_pkg: shared branch-tracking constants and entry layout for fetch, predictor and resolve blocks
package branch_pkg;
  localparam int PC_W = 32;
  localparam int DEPTH = 4;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic pred;
    logic [PC_W-1:0] target;
  } br_entry_t;
endpackage

// File: rtl/branch_info_fifo.sv
// branch_info_fifo: circular buffer of in-flight branches with head/tail pointers, count and flush
module branch_info_fifo #(
  parameter int DEPTH = branch_pkg::DEPTH,
  parameter int PC_W = branch_pkg::PC_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic push_i,
  input  logic [PC_W-1:0] push_pc_i,
  input  logic push_pred_i,
  input  logic [PC_W-1:0] push_target_i,
  input  logic pop_i,
  output logic [PC_W-1:0] head_pc_o,
  output logic head_pred_o,
  output logic [PC_W-1:0] head_target_o,
  output logic [CW-1:0] count_o
);
  logic [PC_W-1:0] pc_q [DEPTH];
  logic pred_q [DEPTH];
  logic [PC_W-1:0] target_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic push_ok;
  assign push_ok = push_i && !flush_i;
  // Next pointers: a flush empties the queue and drops any same-cycle push; pointers wrap naturally
  always_comb begin
    head_d = flush_i ? '0 : head_q + AW'(pop_i);
    tail_d = flush_i ? '0 : tail_q + AW'(push_ok);
    count_d = flush_i ? '0 : count_q + CW'(push_ok) - CW'(pop_i);
  end
  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // Entry storage; contents need no reset since count gates their use
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      pc_q[tail_q] <= push_pc_i;
      pred_q[tail_q] <= push_pred_i;
      target_q[tail_q] <= push_target_i;
    end
  end
  assign head_pc_o = pc_q[head_q];
  assign head_pred_o = pred_q[head_q];
  assign head_target_o = target_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: retires predicted branches in order, trains the predictor and redirects fetch on mispredict
module branch_resolve_queue #(
  parameter int DEPTH = branch_pkg::DEPTH,
  parameter int PC_W = branch_pkg::PC_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic alloc_valid,
  input  logic [PC_W-1:0] alloc_pc,
  input  logic alloc_pred,
  input  logic [PC_W-1:0] alloc_target,
  output logic alloc_ready,
  input  logic resolve_valid,
  input  logic resolve_taken,
  output logic update_en,
  output logic [PC_W-1:0] pc_bits,
  output logic outcome,
  output logic mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic resolve_err,
  output logic [CW-1:0] count
);
  import branch_pkg::*;
  logic [PC_W-1:0] head_pc, head_target;
  logic head_pred, pop, wrong, flush;
  logic update_en_q, update_en_d, outcome_q, outcome_d, mispredict_q, mispredict_d, resolve_err_q, resolve_err_d;
  logic [PC_W-1:0] pc_bits_q, pc_bits_d, redirect_pc_q, redirect_pc_d;
  assign alloc_ready = count != CW'(DEPTH);
  assign pop = resolve_valid && count != '0;
  assign wrong = head_pred != resolve_taken;
  assign flush = pop && wrong;
  branch_info_fifo #(.DEPTH(DEPTH), .PC_W(PC_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush_i(flush),
    .push_i(alloc_valid && alloc_ready),
    .push_pc_i(alloc_pc),
    .push_pred_i(alloc_pred),
    .push_target_i(alloc_target),
    .pop_i(pop),
    .head_pc_o(head_pc),
    .head_pred_o(head_pred),
    .head_target_o(head_target),
    .count_o(count)
  );
  // Training/redirect results for the next cycle; data fields hold when no resolve retires
  always_comb begin
    update_en_d = pop;
    mispredict_d = flush;
    resolve_err_d = resolve_valid && count == '0;
    outcome_d = pop ? resolve_taken : outcome_q;
    pc_bits_d = pop ? head_pc : pc_bits_q;
    redirect_pc_d = !pop ? redirect_pc_q : resolve_taken ? head_target : head_pc + PC_W'(INSTR_BYTES);
  end
  // Output registers; reset also suppresses any pulse that would have fired next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      update_en_q <= 1'b0;
      outcome_q <= 1'b0;
      mispredict_q <= 1'b0;
      resolve_err_q <= 1'b0;
      pc_bits_q <= '0;
      redirect_pc_q <= '0;
    end else begin
      update_en_q <= update_en_d;
      outcome_q <= outcome_d;
      mispredict_q <= mispredict_d;
      resolve_err_q <= resolve_err_d;
      pc_bits_q <= pc_bits_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
  assign update_en = update_en_q;
  assign outcome = outcome_q;
  assign mispredict = mispredict_q;
  assign resolve_err = resolve_err_q;
  assign pc_bits = pc_bits_q;
  assign redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed vector table plus randomized run against a queue-based reference model
module tb_branch_resolve_queue;
  import branch_pkg::*;
  logic clk = 0;
  logic reset, alloc_valid, alloc_pred, resolve_valid, resolve_taken;
  logic [31:0] alloc_pc, alloc_target;
  logic alloc_ready, update_en, outcome, mispredict, resolve_err;
  logic [31:0] pc_bits, redirect_pc;
  logic [2:0] count;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  branch_resolve_queue dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred), .alloc_target(alloc_target),
    .alloc_ready(alloc_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .update_en(update_en), .pc_bits(pc_bits), .outcome(outcome),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .resolve_err(resolve_err), .count(count)
  );
  typedef struct {
    logic rst, av;
    logic [31:0] apc;
    logic apred;
    logic [31:0] atgt;
    logic rv, rt, ue;
    logic [31:0] pcb;
    logic out, mis;
    logic [31:0] rpc;
    logic err;
    logic [2:0] cnt;
    logic rdy;
  } vec_t;
  vec_t tbl[$];
  br_entry_t mq[$];
  logic m_ue, m_out, m_mis, m_err;
  logic [31:0] m_pcb, m_rpc;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endfunction
  function automatic void addv(logic rst, logic av, logic [31:0] apc, logic apred, logic [31:0] atgt,
      logic rv, logic rt, logic ue, logic [31:0] pcb, logic out, logic mis, logic [31:0] rpc,
      logic err, logic [2:0] cnt, logic rdy);
    tbl.push_back('{rst, av, apc, apred, atgt, rv, rt, ue, pcb, out, mis, rpc, err, cnt, rdy});
  endfunction
  task automatic drive(logic rst, logic av, logic [31:0] apc, logic apred, logic [31:0] atgt, logic rv, logic rt);
    reset = rst; alloc_valid = av; alloc_pc = apc; alloc_pred = apred; alloc_target = atgt;
    resolve_valid = rv; resolve_taken = rt;
  endtask
  task automatic cycle(string tag);
    logic ready;
    br_entry_t e;
    ready = mq.size() < DEPTH;
    chk({tag, " alloc_ready"}, alloc_ready, ready);
    if (reset) begin
      mq.delete();
      {m_ue, m_out, m_mis, m_err, m_pcb, m_rpc} = '0;
    end else begin
      m_err = resolve_valid && mq.size() == 0;
      m_ue = resolve_valid && mq.size() != 0;
      m_mis = 1'b0;
      if (m_ue) begin
        e = mq.pop_front();
        m_out = resolve_taken;
        m_pcb = e.pc;
        m_mis = e.pred != resolve_taken;
        m_rpc = resolve_taken ? e.target : e.pc + 32'd4;
        if (m_mis) mq.delete();
      end
      if (alloc_valid && ready && !m_mis) mq.push_back('{pc: alloc_pc, pred: alloc_pred, target: alloc_target});
    end
    @(posedge clk);
    #1;
    chk({tag, " update_en"}, update_en, m_ue);
    chk({tag, " pc_bits"}, pc_bits, m_pcb);
    chk({tag, " outcome"}, outcome, m_out);
    chk({tag, " mispredict"}, mispredict, m_mis);
    chk({tag, " redirect_pc"}, redirect_pc, m_rpc);
    chk({tag, " resolve_err"}, resolve_err, m_err);
    chk({tag, " count"}, count, mq.size());
  endtask
  initial begin
    logic [31:0] ppc, prpc;
    logic pout;
    addv(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);
    addv(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);
    addv(0,1,'h100,1,'h200,0,0, 0,0,0,0,0,0,1,1);
    addv(0,0,0,0,0,1,1, 1,'h100,1,0,'h200,0,0,1);
    addv(0,1,'h40,1,'h80,0,0, 0,'h100,1,0,'h200,0,1,1);
    addv(0,0,0,0,0,1,0, 1,'h40,0,1,'h44,0,0,1);
    addv(0,1,'hFFFFFFFC,0,'h10,0,0, 0,'h40,0,0,'h44,0,1,1);
    addv(0,0,0,0,0,1,0, 1,'hFFFFFFFC,0,0,0,0,0,1);
    addv(0,1,'hFFFFFFFC,0,'h10,0,0, 0,'hFFFFFFFC,0,0,0,0,1,1);
    addv(0,0,0,0,0,1,1, 1,'hFFFFFFFC,1,1,'h10,0,0,1);
    for (int i = 0; i < 4; i++)
      addv(0,1,'h1000+4*i,0,'h2000+4*i,0,0, 0,'hFFFFFFFC,1,0,'h10,0,3'(i+1),i < 3);
    addv(0,1,'h5000,1,'h5004,0,0, 0,'hFFFFFFFC,1,0,'h10,0,4,0);
    addv(0,1,'h6000,1,'h6004,1,1, 1,'h1000,1,1,'h2000,0,0,1);
    addv(0,1,'h300,1,'h400,0,0, 0,'h1000,1,0,'h2000,0,1,1);
    addv(0,1,'h500,1,'h600,1,0, 1,'h300,0,1,'h304,0,0,1);
    addv(0,0,0,0,0,1,0, 0,'h300,0,0,'h304,1,0,1);
    addv(0,0,0,0,0,0,0, 0,'h300,0,0,'h304,0,0,1);
    addv(0,1,'h700,1,'h800,1,1, 0,'h300,0,0,'h304,1,1,1);
    addv(0,0,0,0,0,1,1, 1,'h700,1,0,'h800,0,0,1);
    addv(0,1,'h10,1,'h20,0,0, 0,'h700,1,0,'h800,0,1,1);
    addv(0,1,'h14,1,'h24,1,1, 1,'h10,1,0,'h20,0,1,1);
    addv(0,0,0,0,0,1,1, 1,'h14,1,0,'h24,0,0,1);
    for (int i = 0; i < 3; i++)
      addv(0,1,'hA0+4*i,1,'hB0,0,0, 0,'h14,1,0,'h24,0,3'(i+1),1);
    addv(1,0,0,0,0,1,1, 0,0,0,0,0,0,0,1);
    addv(0,0,0,0,0,1,1, 0,0,0,0,0,1,0,1);
    ppc = 0; prpc = 0; pout = 0;
    for (int i = 0; i < 6; i++) begin
      addv(0,1,4*i,1,'h100+4*i,0,0, 0,ppc,pout,0,prpc,0,1,1);
      addv(0,0,0,0,0,1,1, 1,4*i,1,0,'h100+4*i,0,0,1);
      ppc = 4*i; prpc = 'h100+4*i; pout = 1;
    end
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].apc, tbl[i].apred, tbl[i].atgt, tbl[i].rv, tbl[i].rt);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d update_en", i), update_en, tbl[i].ue);
      chk($sformatf("v%0d pc_bits", i), pc_bits, tbl[i].pcb);
      chk($sformatf("v%0d outcome", i), outcome, tbl[i].out);
      chk($sformatf("v%0d mispredict", i), mispredict, tbl[i].mis);
      chk($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].rpc);
      chk($sformatf("v%0d resolve_err", i), resolve_err, tbl[i].err);
      chk($sformatf("v%0d count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d alloc_ready", i), alloc_ready, tbl[i].rdy);
    end
    drive(1,0,0,0,0,0,0);
    cycle("sync_reset");
    for (int i = 0; i < 4; i++) begin
      drive(0,1,'h900+4*i,1,'hA00+4*i,0,0);
      cycle("fill");
    end
    drive(0,1,'h990,1,'h994,1,1);
    cycle("full_resolve_no_bypass");
    chk("full_resolve count", count, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0,0,0,0,0,1,1);
      cycle("drain");
    end
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom, 1'($urandom),
            $urandom, $urandom_range(0, 1), 1'($urandom));
      cycle($sformatf("rnd%0d", i));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue that records every predicted branch at fetch and retires it when execute resolves it. It is the feedback end of the tournament predictor interface: it drives the predictor's `update_en`, `outcome` and `pc_bits` inputs, and it raises a redirect to fetch on a mispredict. It sits between the fetch stage (allocation side), the execute stage (resolution side) and the predictor (training side).

## Interface
- `DEPTH`, 4, number of in-flight branch entries; power of two, ≥2
- `PC_W`, 32, program-counter width
- `clk` in 1, single clock, all state on rising edge
- `reset` in 1, synchronous, active-high
- `alloc_valid` in 1, fetch records a predicted branch this cycle
- `alloc_pc` in PC_W, branch PC
- `alloc_pred` in 1, predicted direction (1 = taken)
- `alloc_target` in PC_W, taken target
- `alloc_ready` out 1, combinational, high when count < DEPTH
- `resolve_valid` in 1, execute resolves the oldest outstanding branch
- `resolve_taken` in 1, actual direction
- `update_en` out 1, one-cycle training strobe to predictor
- `pc_bits` out PC_W, PC of the trained branch
- `outcome` out 1, actual direction for training
- `mispredict` out 1, one-cycle pulse, prediction was wrong
- `redirect_pc` out PC_W, correct next PC, valid with `mispredict`
- `resolve_err` out 1, one-cycle pulse, resolve arrived with the queue empty
- `count` out $clog2(DEPTH)+1, current occupancy

## Operation
- Storage: circular buffer of {pc, pred, target}, with head (oldest) and tail pointers of $clog2(DEPTH) bits; pointers wrap modulo DEPTH. `count` is tracked separately.
- Allocate: `alloc_valid && alloc_ready` writes the entry at tail and advances tail.
- Resolve: `resolve_valid && count != 0` pops head. On the following cycle:
  - `update_en`=1, `pc_bits`=head.pc, `outcome`=`resolve_taken`.
  - `mispredict`=(head.pred != `resolve_taken`).
  - `redirect_pc`=head.target if taken, else head.pc+4 (modulo 2^PC_W).
- Resolve on empty: no pop, no `update_en`; `resolve_err`=1 the next cycle.
- Mispredict flush: when a resolve mispredicts, all younger entries are discarded in the same edge. Head=tail=0 and count=0. An allocation in that same cycle is dropped.
- Simultaneous allocate and resolve (no mispredict): both occur; count is unchanged. When full, `alloc_ready`=0 even if a resolve occurs that cycle (no same-cycle bypass).
- Reset: pointers=0, count=0, and `update_en`, `mispredict`, `resolve_err`, `outcome`, `pc_bits`, `redirect_pc` all 0. Reset asserted mid-operation discards all entries, and any output pulse due next cycle is suppressed.
- Reset has priority over flush; flush has priority over allocate.

## Timing
- Resolve in cycle N → `update_en`/`outcome`/`pc_bits`/`mispredict`/`redirect_pc` registered and valid in N+1 only, then low/held.
- `pc_bits`, `outcome` and `redirect_pc` hold their last value when not strobed.
- Allocation in cycle N is resolvable from N+1. A same-cycle allocate into an empty queue with a resolve gives `resolve_err`.
- `alloc_ready` depends only on registered `count` (no combinational path from `resolve_valid`).
- Back-to-back resolves produce back-to-back `update_en` pulses, one per cycle.

## Structure
- Shared package `branch_pkg`: `PC_W`, `DEPTH` defaults, `INSTR_BYTES`=4, and the entry struct/field widths. This is shared with the predictor and fetch blocks.
- One sub-module: `branch_info_fifo`, the circular buffer with pointers, count and a flush input. `branch_resolve_queue` adds the compare/redirect logic and output registers.

## Test plan
- Reset, then idle: all outputs 0, `count`=0, `alloc_ready`=1.
- Allocate pc 0x100 pred=1 target 0x200, then resolve taken=1: next cycle `update_en`=1, `pc_bits`=0x100, `outcome`=1, `mispredict`=0, `count`=0.
- Allocate pc 0x40 pred=1 target 0x80, resolve taken=0: `mispredict`=1, `redirect_pc`=0x44. Also pc 0xFFFFFFFC pred=0 target 0x10, resolve taken=0: `mispredict`=0, and when resolved taken=1, `redirect_pc`=0x10.
- Fill 4 entries: `alloc_ready`=0 and a 5th alloc is dropped. Resolve the first with a mispredict while `alloc_valid`=1: next cycle `count`=0 and the alloc is discarded.
- Resolve on empty: `resolve_err`=1 for one cycle, `update_en`=0, `count` stays 0.
- Allocate 3, pulse `reset` mid-stream coincident with a resolve: next cycle `update_en`=0, `count`=0. Then 6 alloc/resolve pairs wrap pointers, with the correct `pc_bits` order 0x0, 0x4, … 0x14.
